waterfall_fb_sequencer: RTL and testbench
=========================================

// Module: waterfall_fb_sequencer
// PURPOSE
//  Parametrised scrolling frame-buffer sequencer for the waterfall display, sitting between the video timing
//  generator, the single-port frame buffer RAM and a sample source (ADC or FFT bins).
//  Clears the RAM after reset, serves video read addresses with a circular row offset,
//  and during lower blanking writes one new row every SCROLL_DIV frames.
//  Two row-draw modes: BAR (one sample drawn as a bar) and INTENSITY (one sample per pixel, spectrum line).
// PARAMETERS
//  H_RES       320  visible pixels per row
//  V_RES       240  visible rows; also the circular buffer depth in rows
//  PIX_W       8    frame-buffer pixel width, which is also the sample width
//  SCROLL_DIV  4    frames per scroll step, 1..256
//  ADDR_W      17   frame-buffer address width, >= clog2(H_RES*V_RES)
// PORTS
//  clk          in   1        pixel clock; single clock domain
//  resetn       in   1        synchronous, active-low reset
//  x            in   9        current video column
//  y            in   8        current video row
//  lower_blank  in   1        high while video is below the visible area
//  smp_data     in   PIX_W    sample value
//  smp_valid    in   1        sample present
//  smp_ready    out  1        sample consumed on the cycle where smp_valid && smp_ready
//  mode         in   1        0 = BAR, 1 = INTENSITY; sampled on entry to WRITE
//  freeze       in   1        1 = suppress scrolling
//  fb_addr      out  ADDR_W   frame-buffer address
//  fb_wdata     out  PIX_W    frame-buffer write data
//  fb_we        out  1        frame-buffer write enable
//  clear_done   out  1        high once the initial clear has finished
//  row_offset   out  8        current top-row index, 0..V_RES-1
//  underrun     out  1        sticky flag: an INTENSITY pixel had no sample available
// BEHAVIOUR
//  Reset values: fb_addr=0, fb_wdata=0, fb_we=0, smp_ready=0, clear_done=0, row_offset=0, underrun=0,
//   scroll_cnt=0, state=CLEAR.
//  Reset mid-operation: all of the above are restored on the next clk edge, and a partial row is abandoned.
//  CLEAR: fb_we=1, fb_wdata=0, fb_addr counts 0..H_RES*V_RES-1 one per cycle.
//   After the last address: fb_we=0, clear_done=1, go to VIDEO. Takes exactly H_RES*V_RES write cycles.
//  VIDEO read pipeline, 2 clk latency:
//   stage 1: row_mod <= (y+row_offset >= V_RES) ? y+row_offset-V_RES : y+row_offset
//   stage 2: fb_addr <= row_mod*H_RES + x
//   All arithmetic is done at ADDR_W width with no truncation. The downstream stage blanks x<2.
//  VIDEO->WRITE: on the first cycle of lower_blank (rising edge), scroll_cnt increments mod SCROLL_DIV.
//   If it wraps to 0 and freeze=0, go to WRITE. Otherwise go to WAIT.
//  WRITE: column counter c runs 0..H_RES-1, one pixel per cycle; fb_addr=row_offset*H_RES+c; fb_we=1.
//   BAR: on entry, smp_ready=1 for exactly one cycle and the sample latches into bar_val
//    (if smp_valid=0, bar_val=0 and underrun is not set).
//    Pixel value = (c < bar_val) ? bar_val : 0.
//   INTENSITY: smp_ready=1 on every write cycle. Pixel = smp_data when smp_valid=1;
//    otherwise the pixel is 0 and underrun is set to 1.
//   After c=H_RES-1: fb_we=0, smp_ready=0, row_offset <= (row_offset==V_RES-1) ? 0 : row_offset+1,
//    then go to WAIT. The newest row therefore displays at y=V_RES-1.
//   WRITE length is H_RES+1 cycles and must fit within lower blanking.
//  WAIT: hold fb_we=0 until lower_blank=0, then go to VIDEO. This gives exactly one scroll decision per frame.
//  mode and freeze changes take effect only at the next VIDEO->WRITE decision.
//   mode is ignored in every state except the WRITE entry.
//  smp_ready is never high outside WRITE.
// TESTING
//  1 Release resetn -> fb_we=1 for exactly 76800 cycles with addresses 0..76799, then clear_done=1, fb_we=0.
//  2 row_offset=239, y=1, x=5 -> 2 clk later fb_addr=0*320+5=5; with y=0 -> fb_addr=239*320+5=76485.
//  3 BAR, smp_data=5 at entry -> row pixels 0..4 = 5, pixels 5..319 = 0; one smp_ready pulse.
//  4 INTENSITY, smp_valid dropped for pixels 100..109 -> those pixels = 0, underrun=1 and stays set.
//  5 SCROLL_DIV=4, 8 frames -> exactly 2 rows written. freeze=1 over 8 frames -> 0 rows written,
//    row_offset unchanged.
//  6 240 scrolls -> row_offset wraps 239->0. resetn low in the middle of WRITE -> fb_we=0 next cycle,
//    then CLEAR restarts from address 0.

Source files
------------

// File: rtl/waterfall_fb_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : waterfall_fb_sequencer_if
// Brief    : Frame-buffer port and sample-stream handshake for the sequencer.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface waterfall_fb_sequencer_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8
);
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_wdata;
    logic              fb_we;
    logic [PIX_W-1:0]  smp_data;
    logic              smp_valid;
    logic              smp_ready;

    modport master (
        output fb_addr, fb_wdata, fb_we, smp_ready,
        input  smp_data, smp_valid
    );

    modport slave (
        input  fb_addr, fb_wdata, fb_we, smp_ready,
        output smp_data, smp_valid
    );
endinterface
`default_nettype wire

// File: rtl/waterfall_fb_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : waterfall_fb_sequencer
// Brief    : Scrolling waterfall frame-buffer sequencer: clear, circular video
//            reads, and one new row per SCROLL_DIV frames during lower blanking.
// Revision : 1.0
// ---------------------------------------------------------------------------
module waterfall_fb_sequencer #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int PIX_W      = 8,
    parameter int SCROLL_DIV = 4,
    parameter int ADDR_W     = 17
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    input  wire logic [8:0]   x,
    input  wire logic [7:0]   y,
    input  wire logic         lower_blank,
    input  wire logic         mode,
    input  wire logic         freeze,
    waterfall_fb_sequencer_if.master fb,
    output logic              clear_done,
    output logic [7:0]        row_offset,
    output logic              underrun
);
    localparam int                COL_W      = $clog2(H_RES + 1);
    localparam logic [ADDR_W-1:0] c_H_RES    = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] c_V_RES    = ADDR_W'(V_RES);
    localparam logic [ADDR_W-1:0] c_CLR_LAST = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [COL_W-1:0]  c_COL_END  = COL_W'(H_RES);
    localparam logic [COL_W-1:0]  c_COL_LAST = COL_W'(H_RES - 1);
    localparam logic [7:0]        c_ROW_LAST = 8'(V_RES - 1);
    localparam logic [7:0]        c_DIV_LAST = 8'(SCROLL_DIV - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_VIDEO = 2'd1,
        S_WRITE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t             r_state, w_state;
    logic [ADDR_W-1:0]  r_fb_addr, w_fb_addr;
    logic [PIX_W-1:0]   r_fb_wdata, w_fb_wdata;
    logic               r_fb_we, w_fb_we;
    logic               r_smp_ready, w_smp_ready;
    logic               r_clear_done, w_clear_done;
    logic [7:0]         r_row_offset, w_row_offset;
    logic               r_underrun, w_underrun;
    logic [7:0]         r_scroll_cnt, w_scroll_cnt;
    logic [COL_W-1:0]   r_col, w_col;
    logic [PIX_W-1:0]   r_bar_val, w_bar_val;
    logic               r_mode, w_mode;
    logic               r_lb_d;
    logic [ADDR_W-1:0]  r_row_mod, w_row_mod, w_row_sum, w_rd_addr;
    logic [8:0]         r_x_d;
    logic [PIX_W-1:0]   w_sample, w_bar;

    assign fb.fb_addr   = r_fb_addr;
    assign fb.fb_wdata  = r_fb_wdata;
    assign fb.fb_we     = r_fb_we;
    assign fb.smp_ready = r_smp_ready;
    assign clear_done   = r_clear_done;
    assign row_offset   = r_row_offset;
    assign underrun     = r_underrun;

    // Video read pipeline: stage 1 folds the circular row, stage 2 forms the address.
    assign w_row_sum = ADDR_W'(y) + ADDR_W'(r_row_offset);
    assign w_row_mod = (w_row_sum >= c_V_RES) ? (w_row_sum - c_V_RES) : w_row_sum;
    assign w_rd_addr = r_row_mod * c_H_RES + ADDR_W'(r_x_d);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_CLEAR;
            r_fb_addr    <= '0;
            r_fb_wdata   <= '0;
            r_fb_we      <= 1'b0;
            r_smp_ready  <= 1'b0;
            r_clear_done <= 1'b0;
            r_row_offset <= '0;
            r_underrun   <= 1'b0;
            r_scroll_cnt <= '0;
            r_col        <= '0;
            r_bar_val    <= '0;
            r_mode       <= 1'b0;
            r_lb_d       <= 1'b0;
            r_row_mod    <= '0;
            r_x_d        <= '0;
        end else begin
            r_state      <= w_state;
            r_fb_addr    <= w_fb_addr;
            r_fb_wdata   <= w_fb_wdata;
            r_fb_we      <= w_fb_we;
            r_smp_ready  <= w_smp_ready;
            r_clear_done <= w_clear_done;
            r_row_offset <= w_row_offset;
            r_underrun   <= w_underrun;
            r_scroll_cnt <= w_scroll_cnt;
            r_col        <= w_col;
            r_bar_val    <= w_bar_val;
            r_mode       <= w_mode;
            r_lb_d       <= lower_blank;
            r_row_mod    <= w_row_mod;
            r_x_d        <= x;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_fb_addr    = r_fb_addr;
        w_fb_wdata   = r_fb_wdata;
        w_fb_we      = r_fb_we;
        w_smp_ready  = 1'b0;
        w_clear_done = r_clear_done;
        w_row_offset = r_row_offset;
        w_underrun   = r_underrun;
        w_scroll_cnt = r_scroll_cnt;
        w_col        = r_col;
        w_bar_val    = r_bar_val;
        w_mode       = r_mode;
        w_sample     = fb.smp_valid ? fb.smp_data : '0;
        w_bar        = (r_col == '0) ? w_sample : r_bar_val;

        case (r_state)
            S_CLEAR: begin
                w_fb_wdata = '0;
                if (!r_fb_we) begin
                    w_fb_we   = 1'b1;
                    w_fb_addr = '0;
                end else if (r_fb_addr == c_CLR_LAST) begin
                    w_fb_we      = 1'b0;
                    w_clear_done = 1'b1;
                    w_state      = S_VIDEO;
                end else begin
                    w_fb_addr = r_fb_addr + 1'b1;
                end
            end
            S_VIDEO: begin
                w_fb_we   = 1'b0;
                w_fb_addr = w_rd_addr;
                if (lower_blank && !r_lb_d) begin
                    w_scroll_cnt = (r_scroll_cnt == c_DIV_LAST) ? 8'd0 : r_scroll_cnt + 8'd1;
                    if ((r_scroll_cnt == c_DIV_LAST) && !freeze) begin
                        w_state     = S_WRITE;
                        w_mode      = mode;
                        w_col       = '0;
                        w_smp_ready = 1'b1;
                    end else begin
                        w_state = S_WAIT;
                    end
                end
            end
            S_WRITE: begin
                // First cycle only fetches; each later cycle writes the pixel fetched before it.
                if (r_col == c_COL_END) begin
                    w_fb_we      = 1'b0;
                    w_fb_wdata   = '0;
                    w_row_offset = (r_row_offset == c_ROW_LAST) ? 8'd0 : r_row_offset + 8'd1;
                    w_state      = S_WAIT;
                end else begin
                    w_fb_we     = 1'b1;
                    w_fb_addr   = ADDR_W'(r_row_offset) * c_H_RES + ADDR_W'(r_col);
                    w_col       = r_col + 1'b1;
                    w_smp_ready = r_mode && (r_col != c_COL_LAST);
                    if (r_mode) begin
                        w_fb_wdata = w_sample;
                        if (!fb.smp_valid) w_underrun = 1'b1;
                    end else begin
                        w_bar_val  = w_bar;
                        w_fb_wdata = (ADDR_W'(r_col) < ADDR_W'(w_bar)) ? w_bar : '0;
                    end
                end
            end
            S_WAIT: begin
                w_fb_we   = 1'b0;
                w_fb_addr = w_rd_addr;
                if (!lower_blank) w_state = S_VIDEO;
            end
            default: w_state = S_CLEAR;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_waterfall_fb_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_waterfall_fb_sequencer
// Brief    : Directed self-checking bench on a reduced 32x24 frame buffer.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_waterfall_fb_sequencer;
    localparam int H = 32;
    localparam int V = 24;
    localparam int AW = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [8:0] x = '0;
    logic [7:0] y = '0;
    logic       lower_blank = 1'b0;
    logic       mode = 1'b0;
    logic       freeze = 1'b0;
    logic       clear_done;
    logic [7:0] row_offset;
    logic       underrun;

    logic       src_mode = 1'b0;
    logic [7:0] bar_sample = '0;
    logic       bar_valid = 1'b0;
    int         drop_lo = 1000;
    int         drop_hi = 0;
    int         rdy_idx = 0;

    logic [7:0] mem [0:H*V-1];
    int         wr_cnt = 0;
    int         rdy_cnt = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    waterfall_fb_sequencer_if #(.ADDR_W(AW), .PIX_W(8)) fb();

    waterfall_fb_sequencer #(
        .H_RES(H), .V_RES(V), .PIX_W(8), .SCROLL_DIV(4), .ADDR_W(AW)
    ) dut (
        .clk(clk), .resetn(resetn), .x(x), .y(y), .lower_blank(lower_blank),
        .mode(mode), .freeze(freeze), .fb(fb), .clear_done(clear_done),
        .row_offset(row_offset), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Sample source: pattern indexed by position inside the current ready burst.
    always @(posedge clk) rdy_idx <= fb.smp_ready ? rdy_idx + 1 : 0;
    assign fb.smp_data  = src_mode ? 8'(rdy_idx * 3 + 7) : bar_sample;
    assign fb.smp_valid = src_mode ? !(rdy_idx >= drop_lo && rdy_idx <= drop_hi) : bar_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (fb.fb_we) begin
            mem[fb.fb_addr] = fb.fb_wdata;
            wr_cnt++;
        end
        if (fb.smp_ready) rdy_cnt++;
    endtask

    task automatic frame();
        lower_blank = 1'b0;
        repeat (10) tick();
        lower_blank = 1'b1;
        repeat (40) tick();
        lower_blank = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    // kind 0: bar of height/value bv; kind 1: intensity pattern with drop window.
    function automatic logic [7:0] exp_pix(input int kind, input int k, input int bv, input int lo, input int hi);
        if (kind == 0) return (k < bv) ? 8'(bv) : 8'd0;
        return (k >= lo && k <= hi) ? 8'd0 : 8'(k * 3 + 7);
    endfunction

    task automatic check_row(input string tag, input int row, input int kind, input int bv, input int lo, input int hi);
        int errs = 0;
        for (int k = 0; k < H; k++)
            if (mem[row * H + k] !== exp_pix(kind, k, bv, lo, hi)) errs++;
        check(tag, errs, 0);
    endtask

    task automatic read_at(input string tag, input int yy, input int xx, input int exp);
        y = 8'(yy);
        x = 9'(xx);
        repeat (3) tick();
        check(tag, 32'(fb.fb_addr), exp);
    endtask

    initial begin
        int n, seq_err, nz, w0, r0, ro;
        bit found;
        for (int i = 0; i < H * V; i++) mem[i] = 8'hAA;

        repeat (3) tick();
        check("rst_we", fb.fb_we, 0);
        check("rst_addr", fb.fb_addr, 0);
        check("rst_ready", fb.smp_ready, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_row_offset", row_offset, 0);
        check("rst_underrun", underrun, 0);

        // Clear sweep
        resetn = 1'b1;
        n = 0; seq_err = 0;
        for (int c = 0; c < 2000 && !clear_done; c++) begin
            tick();
            if (fb.fb_we) begin
                if (fb.fb_addr != AW'(n)) seq_err++;
                n++;
            end
        end
        check("clear_count", n, H * V);
        check("clear_seq", seq_err, 0);
        check("clear_done", clear_done, 1);
        check("clear_we_low", fb.fb_we, 0);
        nz = 0;
        for (int i = 0; i < H * V; i++) if (mem[i] !== 8'h00) nz++;
        check("clear_zero", nz, 0);

        read_at("rd_y3_x7", 3, 7, 3 * H + 7);
        read_at("rd_y23_x31", 23, 31, 23 * H + 31);

        // BAR rows
        for (int k = 0; k < H; k++) mem[k] = 8'hEE;
        bar_sample = 8'd5; bar_valid = 1'b1; mode = 1'b0; src_mode = 1'b0;
        w0 = wr_cnt; r0 = rdy_cnt;
        frames(4);
        check("bar5_writes", wr_cnt - w0, H);
        check("bar5_ready_pulses", rdy_cnt - r0, 1);
        check_row("bar5_row0", 0, 0, 5, 0, 0);
        check("bar5_row_offset", row_offset, 1);

        bar_sample = 8'd40;
        frames(4);
        check_row("bar40_row1", 1, 0, 40, 0, 0);

        for (int k = 0; k < H; k++) mem[2 * H + k] = 8'hEE;
        bar_valid = 1'b0;
        frames(4);
        check_row("bar_nosmp_row2", 2, 0, 0, 0, 0);
        check("bar_nosmp_underrun", underrun, 0);
        check("bar_row_offset", row_offset, 3);

        // INTENSITY rows
        mode = 1'b1; src_mode = 1'b1; drop_lo = 10; drop_hi = 13;
        r0 = rdy_cnt;
        frames(4);
        check("int_ready_cycles", rdy_cnt - r0, H);
        check_row("int_drop_row3", 3, 1, 0, 10, 13);
        check("int_underrun_set", underrun, 1);
        drop_lo = 1000; drop_hi = 0;
        frames(4);
        check_row("int_clean_row4", 4, 1, 0, 1000, 0);
        check("int_underrun_sticky", underrun, 1);

        // Freeze, then scroll divider
        freeze = 1'b1;
        w0 = wr_cnt; ro = row_offset;
        frames(8);
        check("freeze_writes", wr_cnt - w0, 0);
        check("freeze_row_offset", row_offset, ro);
        freeze = 1'b0;
        w0 = wr_cnt;
        frames(8);
        check("div4_writes", wr_cnt - w0, 2 * H);
        check("div4_row_offset", row_offset, 7);

        // Circular read addressing at the top row
        frames(64);
        check("pre_wrap_row_offset", row_offset, V - 1);
        read_at("wrap_rd_y1", 1, 5, 5);
        read_at("wrap_rd_y0", 0, 5, (V - 1) * H + 5);
        read_at("wrap_rd_y23", 23, 5, 22 * H + 5);
        frames(4);
        check("wrap_row_offset", row_offset, 0);

        // Reset in the middle of a row write
        mode = 1'b0; bar_valid = 1'b1; bar_sample = 8'd9;
        frames(3);
        lower_blank = 1'b0;
        repeat (10) tick();
        lower_blank = 1'b1;
        repeat (10) tick();
        check("midwrite_we", fb.fb_we, 1);
        resetn = 1'b0;
        tick();
        check("midrst_we", fb.fb_we, 0);
        check("midrst_underrun", underrun, 0);
        check("midrst_clear_done", clear_done, 0);
        resetn = 1'b1;
        lower_blank = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (fb.fb_we) found = 1'b1;
        end
        check("reclear_started", found, 1);
        check("reclear_addr0", fb.fb_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
